// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller.
//   intr_state_t  : controller handshake state (IDLE, REQ, SERV)
//   N_IRQ_DEFAULT : default number of interrupt sources
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } intr_state_t;

  localparam int unsigned N_IRQ_DEFAULT = 8;

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder; the highest set index wins.
//   req : request bits, one per source
//   idx : index of the highest set bit (0 when none set)
//   any : at least one request bit set
module intr_prio_enc #(
  parameter  int unsigned N_IRQ = 8,
  localparam int unsigned VEC_W = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  output logic [VEC_W-1:0] idx,
  output logic             any
);

  // Ascending scan: a later (higher) hit overwrites an earlier one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (req[i]) begin
        idx = VEC_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge/level pending latches, per-source masking,
// global enable and a request/ack/eoi handshake with a single in-service slot.
//   clk, rst   : clock, synchronous active-high reset
//   irq_in     : raw interrupt lines
//   edge_mode  : per source, 1 = rising-edge, 0 = level
//   mask       : per source enable
//   ena        : global enable
//   ack, eoi   : CPU accept / end-of-interrupt pulses
//   intr_req   : registered request to the core
//   vec        : registered vector of requested / in-service source
//   in_service : high from accepted ack until eoi
//   pending    : pending register readback
module intr_ctrl
  import intr_pkg::*;
#(
  parameter  int unsigned N_IRQ = N_IRQ_DEFAULT,
  localparam int unsigned VEC_W = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] edge_mode,
  input  logic [N_IRQ-1:0] mask,
  input  logic             ena,
  input  logic             ack,
  input  logic             eoi,
  output logic             intr_req,
  output logic [VEC_W-1:0] vec,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  intr_state_t      state_q, state_d;
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             intr_req_q, intr_req_d;
  logic             in_service_q, in_service_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] cand;
  logic [VEC_W-1:0] enc_idx;
  logic             enc_any;

  intr_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .req (cand),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    irq_d = irq_in;
    rise  = irq_in & ~irq_q;
    cand  = pending_q & mask;

    clr = '0;
    if ((state_q == REQ) && ack && edge_mode[vec_q]) begin
      clr[vec_q] = 1'b1;
    end

    // Edge sources: set beats clear. Level sources track the line directly.
    pending_d = (edge_mode & (rise | (pending_q & ~clr))) | (~edge_mode & irq_in);
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    intr_req_d   = intr_req_q;
    in_service_d = in_service_q;
    unique case (state_q)
      IDLE: begin
        if (ena && enc_any) begin
          state_d    = REQ;
          vec_d      = enc_idx;
          intr_req_d = 1'b1;
        end
      end
      REQ: begin
        if (ack) begin
          state_d      = SERV;
          intr_req_d   = 1'b0;
          in_service_d = 1'b1;
        end else if (!ena || !cand[vec_q]) begin
          state_d    = IDLE;
          intr_req_d = 1'b0;
        end
      end
      SERV: begin
        if (eoi) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        intr_req_d   = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      vec_q        <= '0;
      intr_req_q   <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      pending_q    <= pending_d;
      vec_q        <= vec_d;
      intr_req_q   <= intr_req_d;
      in_service_q <= in_service_d;
    end
  end

  assign intr_req   = intr_req_q;
  assign vec        = vec_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  typedef struct {
    bit       req;
    bit       serv;
    bit [7:0] pend;
    bit [2:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq = '0, edge_mode = '0, mask = '1;
  logic       ena = 1'b1, ack = 1'b0, eoi = 1'b0;
  logic       intr_req, in_service;
  logic [2:0] vec;
  logic [7:0] pending;

  logic [15:0] irq16 = '0, edge16 = '1, mask16 = '1;
  logic        ack16 = 1'b0, eoi16 = 1'b0, ena16 = 1'b1;
  logic        req16, serv16;
  logic [3:0]  vec16;
  logic [15:0] pend16;

  int unsigned n_checks = 0, n_pass = 0;
  exp_t        sb[$];

  // Reference model: what the controller should look like after each edge.
  bit [7:0]    m_pend = '0, m_last = '0;
  bit          m_req = 1'b0, m_serv = 1'b0;
  int unsigned m_vec = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.N_IRQ(8)) dut (
    .clk(clk), .rst(rst), .irq_in(irq), .edge_mode(edge_mode), .mask(mask),
    .ena(ena), .ack(ack), .eoi(eoi), .intr_req(intr_req), .vec(vec),
    .in_service(in_service), .pending(pending)
  );

  intr_ctrl #(.N_IRQ(16)) dut16 (
    .clk(clk), .rst(rst), .irq_in(irq16), .edge_mode(edge16), .mask(mask16),
    .ena(ena16), .ack(ack16), .eoi(eoi16), .intr_req(req16), .vec(vec16),
    .in_service(serv16), .pending(pend16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    bit [7:0] rise, cand, np;
    if (rst) begin
      m_pend = '0; m_last = '0; m_req = 0; m_serv = 0; m_vec = 0;
      return;
    end
    rise = irq & ~m_last;
    cand = m_pend & mask;
    for (int i = 0; i < 8; i++) begin
      if (edge_mode[i])
        np[i] = rise[i] || (m_pend[i] && !(m_req && ack && m_vec == i));
      else
        np[i] = irq[i];
    end
    if (m_req) begin
      if (ack) begin m_req = 0; m_serv = 1; end
      else if (!ena || !cand[m_vec]) m_req = 0;
    end else if (m_serv) begin
      if (eoi) m_serv = 0;
    end else if (ena && cand != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (cand[i]) begin m_vec = i; break; end
      end
      m_req = 1;
    end
    m_pend = np;
    m_last = irq;
  endtask

  // One clock with the current inputs; model advanced and expectation queued.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    e.req = m_req; e.serv = m_serv; e.pend = m_pend; e.vec = 3'(m_vec);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1; irq = '0; ack = 0; eoi = 0;
    step(); step();
    rst = 0;
  endtask

  // Monitor: compare every presented output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("intr_req",   32'(intr_req),   32'(e.req));
        chk("in_service", 32'(in_service), 32'(e.serv));
        chk("pending",    32'(pending),    32'(e.pend));
        chk("vec",        32'(vec),        32'(e.vec));
      end
    end
  end

  initial begin
    do_reset();
    chk("reset_req", 32'(intr_req), 0);
    chk("reset_pend", 32'(pending), 0);

    // Edge source 3, basic handshake
    edge_mode = 8'h08; ena = 1; mask = '1;
    step();
    irq[3] = 1; step();
    irq[3] = 0; step();
    chk("e3_req", 32'(intr_req), 1);
    chk("e3_vec", 32'(vec), 3);
    ack = 1; step(); ack = 0;
    chk("e3_pend_clr", 32'(pending[3]), 0);
    chk("e3_serv", 32'(in_service), 1);
    eoi = 1; step(); eoi = 0;
    step(); step();
    chk("e3_no_rereq", 32'(intr_req), 0);

    // Priority 6 over 2
    do_reset();
    edge_mode = 8'h44;
    irq = 8'h44; step();
    irq = 8'h00; step();
    chk("prio_first", 32'(vec), 6);
    ack = 1; step(); ack = 0;
    eoi = 1; step(); eoi = 0;
    step();
    chk("prio_second", 32'(vec), 2);
    ack = 1; step(); ack = 0;
    eoi = 1; step(); eoi = 0;

    // Level source 5: re-request, then withdraw on drop
    do_reset();
    edge_mode = 8'h00;
    irq[5] = 1; step(); step();
    ack = 1; step(); ack = 0;
    chk("lvl_pend_kept", 32'(pending[5]), 1);
    eoi = 1; step(); eoi = 0;
    step();
    chk("lvl_rereq", 32'(intr_req), 1);
    irq[5] = 0; step(); step();
    chk("lvl_withdraw", 32'(intr_req), 0);

    // Masking and global enable
    do_reset();
    edge_mode = 8'h10; mask = 8'hef;
    irq[4] = 1; step(); irq[4] = 0; step(); step();
    chk("mask_blocks", 32'(intr_req), 0);
    mask = '1; step();
    chk("mask_open_vec", 32'(vec), 4);
    ena = 0; step();
    chk("ena_withdraw", 32'(intr_req), 0);
    chk("ena_pend_kept", 32'(pending[4]), 1);
    ena = 1; step(); step();

    // Set/clear collision on source 1
    do_reset();
    edge_mode = 8'h02;
    irq[1] = 1; step(); irq[1] = 0; step();
    irq[1] = 1; ack = 1; step(); ack = 0;
    chk("coll_pend", 32'(pending[1]), 1);
    eoi = 1; step(); eoi = 0;
    step();
    chk("coll_rereq_vec", 32'(vec), 1);
    chk("coll_rereq", 32'(intr_req), 1);
    irq[1] = 0;

    // Reset while in service with three bits pending
    do_reset();
    edge_mode = '1;
    irq = 8'h55; step(); irq = '0; step();
    ack = 1; step(); ack = 0;
    chk("rst_pre_pend", 32'(pending), 32'h15);
    rst = 1; step(); rst = 0;
    chk("rst_mid_req", 32'(intr_req), 0);
    chk("rst_mid_serv", 32'(in_service), 0);
    chk("rst_mid_pend", 32'(pending), 0);

    // Randomised traffic with the bench acting as the CPU
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 10) irq[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 149) == 0) edge_mode = 8'($urandom);
      if ($urandom_range(0, 99) < 3) mask = 8'($urandom) | 8'($urandom);
      ena = ($urandom_range(0, 19) != 0);
      ack = m_req  ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      eoi = m_serv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; ack = 0; eoi = 0; ena = 1;

    // 16-source instance: source 15 beats source 3
    do_reset();
    irq16 = 16'h8008; step(); irq16 = '0; step();
    chk("n16_req", 32'(req16), 1);
    chk("n16_vec15", 32'(vec16), 15);
    ack16 = 1; step(); ack16 = 0;
    chk("n16_serv", 32'(serv16), 1);
    eoi16 = 1; step(); eoi16 = 0;
    step();
    chk("n16_vec3", 32'(vec16), 3);
    chk("n16_req2", 32'(req16), 1);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised interrupt controller, successor to the fixed 8-input combinational priority encoder. It adds per-source masking, per-source edge or level triggering, pending latches, and a registered vector. A request/acknowledge/end-of-interrupt handshake with the CPU core guarantees one interrupt in service at a time. It sits between peripheral interrupt lines and the MIPS core's exception logic.

## Interface
- `N_IRQ`, 8: number of interrupt sources (2..32).
- `VEC_W`, `$clog2(N_IRQ)`: vector width, derived, not overridden.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `irq_in` in `N_IRQ`: raw interrupt lines, synchronous to `clk`.
- `edge_mode` in `N_IRQ`: per source; 1 = rising-edge triggered, 0 = level triggered.
- `mask` in `N_IRQ`: per source enable; 1 = enabled.
- `ena` in 1: global interrupt enable.
- `ack` in 1: CPU accepts the presented vector (single-cycle pulse).
- `eoi` in 1: CPU finished the handler (single-cycle pulse).
- `intr_req` out 1: interrupt request to the core, registered.
- `vec` out `VEC_W`: vector of the requested or in-service source, registered.
- `in_service` out 1: high from accepted `ack` until `eoi`.
- `pending` out `N_IRQ`: pending register, for status readback.

## Operation
- **Edge detection**
  - `irq_q` is a one-cycle registered copy of `irq_in`.
  - A rising edge is `irq_in & ~irq_q`.
- **Pending, edge sources:** the bit sets on a rising edge and clears only on an accepted `ack` for that source. If a set and a clear hit the same bit in the same cycle, the set wins.
- **Pending, level sources:** the bit follows the registered `irq_in` every cycle. `ack` does not clear it.
- **Candidate and priority**
  - `cand = pending & mask`.
  - Highest index wins, so source `N_IRQ-1` is highest priority.
- **State machine** (`IDLE`, `REQ`, `SERV`):
  - **`IDLE`:** if `ena` and `cand != 0`, latch the priority-encoded index into `vec` and go to `REQ`.
  - **`REQ`:** `intr_req` = 1 and `vec` is held, not re-evaluated.
    - On `ack`: clear pending[vec] if `edge_mode[vec]`, then go to `SERV`.
    - Else, if `ena` = 0 or `cand[vec]` = 0: withdraw and go to `IDLE`.
    - If `ack` and withdraw occur in the same cycle, `ack` wins.
  - **`SERV`:** `intr_req` = 0, `in_service` = 1, `vec` held. On `eoi`, go to `IDLE`.
- **Ignored inputs:** `ack` outside `REQ` and `eoi` outside `SERV` have no effect.
- **No nesting:** higher-priority sources arriving during `SERV` remain pending and are presented after `eoi`.
- **Runtime mode change:** changing `edge_mode` takes effect on the next cycle's pending update.

## Timing
- **Reset values:** state `IDLE`; `intr_req` 0; `vec` 0; `in_service` 0; `pending` 0; `irq_q` 0.
  - Consequence: an edge source high on the first cycle after reset counts as an edge.
- **Request latency:**
  - `irq_in` rises before edge k.
  - Pending is visible after edge k.
  - `intr_req` and `vec` are valid after edge k+1, i.e. 2 cycles.
- **`ack` sampled at edge m:** `intr_req` is 0 and `in_service` is 1 after edge m. The pending clear for an edge source is visible after edge m.
- **`eoi` sampled at edge n:** `in_service` is 0 after edge n. The next request, if any, appears after edge n+1.
- **Withdraw:** `intr_req` drops one cycle after the condition is sampled.
- **`rst` mid-operation:** any state returns to `IDLE` next edge; all pending is lost.

## Structure
- **Package `intr_pkg`:**
  - state enum `intr_state_t` (`IDLE`, `REQ`, `SERV`);
  - default `N_IRQ` constant.
- **Sub-module `intr_prio_enc`:** parametrised combinational highest-index-wins encoder.
  - Inputs: `N_IRQ` request bits.
  - Outputs: `VEC_W` index and an `any` flag.
- The top level holds the edge detector, pending register and FSM.

## Test plan
- **Edge source, basic handshake:** `N_IRQ`=8, all masked in, `ena`=1, `edge_mode[3]`=1, pulse `irq_in[3]`.
  - `intr_req`=1, `vec`=3 two cycles later.
  - `ack` -> `pending[3]`=0, `in_service`=1.
  - `eoi` -> back to `IDLE`, no re-request.
- **Priority:** sources 2 and 6 pend simultaneously -> `vec`=6 first. After `ack`/`eoi`, `vec`=2 is presented.
- **Level source:** `edge_mode[5]`=0, `irq_in[5]` held high through `ack`/`eoi` -> re-requested with `vec`=5. Dropping `irq_in[5]` while in `REQ` withdraws `intr_req` with no `ack`.
- **Masking and global enable:** `mask[4]`=0 with source 4 pending -> no request. Setting `mask[4]`=1 -> `intr_req` with `vec`=4. `ena`=0 while in `REQ` -> withdraw next cycle; pending[4] stays 1.
- **Set/clear collision:** new rising edge on source 1 in the same cycle as `ack` for `vec`=1 -> `pending[1]` remains 1; re-request after `eoi`.
- **Reset mid-service:** assert `rst` while in `SERV` with 3 bits pending -> all outputs 0 next cycle. Run with `N_IRQ`=16 and verify `vec`=15 priority.
